// File: rtl/winograd_pkg.sv
// Shared constants, tile types and saturation helper for the Winograd F(2x2,3x3) datapath.
package winograd_pkg;

    localparam int WINO_M   = 4;   // input tile edge
    localparam int WINO_R   = 3;   // filter taps
    localparam int WINO_OUT = 2;   // output tile edge
    localparam int WINO_W   = 16;  // default element width

    typedef logic [0:WINO_M-1][0:WINO_M-1][WINO_W-1:0]     tile4x4_t;
    typedef logic [0:WINO_OUT-1][0:WINO_OUT-1][WINO_W-1:0] tile2x2_t;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                        input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/winograd_pipe_stage.sv
// Generic valid/ready register slice; full throughput, ready chains combinationally.
module winograd_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: state uses non-blocking assignments; the payload register is reset too so
    // a flushed slice never exposes stale data on its outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/winograd_output_transform.sv
// F(2x2,3x3) output transform Y = A^T*M*A as a two-slice stallable pipeline
// (column pass before slice 1, row pass plus saturation before slice 2).
module winograd_output_transform
    import winograd_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_last,
    input  logic [0:WINO_M-1][0:WINO_M-1][WIDTH-1:0]     M,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last,
    output logic [0:WINO_OUT-1][0:WINO_OUT-1][WIDTH-1:0] Y,
    output logic                                       sat_flag,
    output logic [CNT_WIDTH-1:0]                       sat_count
);

    localparam int TW  = WIDTH + 2;
    localparam int YW  = WIDTH + 4;
    localparam int S1W = WINO_OUT * WINO_M * TW + 1;
    localparam int S2W = WINO_OUT * WINO_OUT * WIDTH + 2;

    // Fractional bits only pass through; the helper works on 32-bit intermediates.
    if (FRAC_WIDTH >= WIDTH || YW > 32) begin : g_param_check
        $error("winograd_output_transform: unsupported WIDTH/FRAC_WIDTH");
    end

    logic signed [TW-1:0] t_in [0:WINO_OUT-1][0:WINO_M-1];
    logic signed [TW-1:0] t_q  [0:WINO_OUT-1][0:WINO_M-1];
    logic signed [YW-1:0] y_full [0:WINO_OUT-1][0:WINO_OUT-1];
    logic signed [31:0]   y_sat  [0:WINO_OUT-1][0:WINO_OUT-1];
    logic [S1W-1:0]       s1_in, s1_q;
    logic [S2W-1:0]       s2_in, s2_q;
    logic                 s1_valid, s2_in_ready, clip_any;

    // Column pass: T = A^T * M.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        s1_in = '0;
        for (int j = 0; j < WINO_M; j++) begin
            t_in[0][j] = '0;
            for (int k = 0; k < WINO_R; k++)
                t_in[0][j] += TW'(signed'(M[k][j]));
            t_in[1][j] = TW'(signed'(M[1][j])) - TW'(signed'(M[2][j])) - TW'(signed'(M[3][j]));
        end
        for (int i = 0; i < WINO_OUT; i++)
            for (int j = 0; j < WINO_M; j++)
                s1_in[(i*WINO_M + j)*TW +: TW] = t_in[i][j];
        s1_in[S1W-1] = in_last;
    end

    winograd_pipe_stage #(.DW(S1W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Row pass: Y' = T * A, exact at WIDTH+4 bits, then clamp each element.
    always_comb begin
        s2_in    = '0;
        clip_any = 1'b0;
        for (int i = 0; i < WINO_OUT; i++) begin
            for (int j = 0; j < WINO_M; j++)
                t_q[i][j] = s1_q[(i*WINO_M + j)*TW +: TW];
            y_full[i][0] = '0;
            for (int k = 0; k < WINO_R; k++)
                y_full[i][0] += YW'(t_q[i][k]);
            y_full[i][1] = YW'(t_q[i][1]) - YW'(t_q[i][2]) - YW'(t_q[i][3]);
            for (int j = 0; j < WINO_OUT; j++) begin
                y_sat[i][j] = sat_to_width(32'(y_full[i][j]), WIDTH);
                clip_any    = clip_any | (y_sat[i][j] != 32'(y_full[i][j]));
                s2_in[(i*WINO_OUT + j)*WIDTH +: WIDTH] = y_sat[i][j][WIDTH-1:0];
            end
        end
        s2_in[S2W-2] = clip_any;
        s2_in[S2W-1] = s1_q[S1W-1];
    end

    winograd_pipe_stage #(.DW(S2W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    always_comb begin
        for (int i = 0; i < WINO_OUT; i++)
            for (int j = 0; j < WINO_OUT; j++)
                Y[i][j] = s2_q[(i*WINO_OUT + j)*WIDTH +: WIDTH];
    end

    assign sat_flag = s2_q[S2W-2];
    assign out_last = s2_q[S2W-1];

    // Counts clipped tiles as they load into slice 2; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (s1_valid && s2_in_ready && clip_any && sat_count != '1)
            sat_count <= sat_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_winograd_output_transform.sv
// Self-checking bench: matrix-level reference model, scoreboard on every output cycle.
module tb_winograd_output_transform;
    import winograd_pkg::*;

    typedef struct packed {
        tile2x2_t y;
        logic     sat;
        logic     last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    tile4x4_t    M = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    tile2x2_t    Y;
    logic        sat_flag;
    logic [15:0] sat_count;

    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    int          or_mode = 0;   // 0: ready, 1: random, 2: back-pressure schedule, 3: stalled
    int          bp_cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mdl_sat_cnt = '0;

    winograd_output_transform #(.WIDTH(16), .FRAC_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .M         (M),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .Y         (Y),
        .sat_flag  (sat_flag),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Y = A^T * M * A computed directly from the transform matrix, then clamped.
    function automatic exp_t model(input tile4x4_t m, input logic last);
        int   at [2][4];
        int   acc;
        exp_t e;
        at[0] = '{1, 1, 1, 0};
        at[1] = '{0, 1, -1, -1};
        e = '0;
        e.last = last;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        acc += at[i][k] * int'($signed(m[k][l])) * at[j][l];
                if (acc > 32767) begin
                    acc = 32767;
                    e.sat = 1'b1;
                end else if (acc < -32768) begin
                    acc = -32768;
                    e.sat = 1'b1;
                end
                e.y[i][j] = 16'(acc);
            end
        return e;
    endfunction

    function automatic tile4x4_t fill(input logic [15:0] v);
        tile4x4_t t;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++)
                t[k][l] = v;
        return t;
    endfunction

    function automatic tile4x4_t rand_tile();
        tile4x4_t t;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++)
                if ($urandom_range(3) == 0)
                    t[k][l] = 16'($urandom);
                else
                    t[k][l] = 16'($urandom_range(2048)) - 16'd1024;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input tile4x4_t t, input logic last);
        in_valid = 1'b1;
        M        = t;
        in_last  = last;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input tile4x4_t t, input tile2x2_t ey,
                            input logic esat);
        send(t, 1'b0);
        @(negedge clk);
        check({nm, "_lat_early"}, out_valid, 0);
        @(negedge clk);
        check({nm, "_lat_valid"}, out_valid, 1);
        check({nm, "_y"}, Y, ey);
        check({nm, "_sat_flag"}, sat_flag, esat);
        tick();
    endtask

    // out_ready driver, updated slightly after the main thread's drive point.
    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            1:       out_ready = ($urandom_range(3) != 0);
            2:       out_ready = !(bp_cyc >= 3 && bp_cyc <= 7);
            3:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
        bp_cyc++;
    end

    // Scoreboard: compare every valid output cycle, then record accepted inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_sat_cnt = '0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    check("spurious_out", out_valid, 0);
                else begin
                    mon_e = exp_q[0];
                    check("stream_y", Y, mon_e.y);
                    check("stream_sat_flag", sat_flag, mon_e.sat);
                    check("stream_last", out_last, mon_e.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e = model(M, in_last);
                exp_q.push_back(mon_e);
                if (mon_e.sat && mdl_sat_cnt != 16'hFFFF)
                    mdl_sat_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tile4x4_t t;
        tile2x2_t ey;
        int       n0;

        // Pin the model with hand-derived tiles.
        check("model_ones", model(fill(16'h0100), 1'b0).y, {16'h0900, 16'hFD00, 16'hFD00, 16'h0100});
        check("model_max", model(fill(16'h7FFF), 1'b0).y, {16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF});
        check("model_max_sat", model(fill(16'h7FFF), 1'b0).sat, 1);

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", Y, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_sat_count", sat_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        // Directed transforms.
        ey = {16'h0900, 16'hFD00, 16'hFD00, 16'h0100};
        directed("ones", fill(16'h0100), ey, 1'b0);
        t = '0;
        t[0][0] = 16'h0100;
        ey = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
        directed("impulse00", t, ey, 1'b0);
        t = '0;
        t[1][1] = 16'h0100;
        ey = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        directed("impulse11", t, ey, 1'b0);
        check("sat_count_before", sat_count, 0);
        ey = {16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
        directed("saturate", fill(16'h7FFF), ey, 1'b1);
        check("sat_count_after", sat_count, 1);

        // Back-pressure: 8 back-to-back tiles, out_ready low in cycles 3..7.
        n0 = n_out;
        bp_cyc  = 0;
        or_mode = 2;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(rand_tile(), 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid_held", out_valid, 1);
            end
        join
        repeat (10) tick();
        or_mode = 0;
        check("bp_all_out", n_out - n0, 8);

        // Last flag with a bubble between tiles.
        tick();
        send(rand_tile(), 1'b0);
        tick();
        send(rand_tile(), 1'b1);
        @(negedge clk);
        check("bubble_gap_valid", out_valid, 0);
        @(negedge clk);
        check("bubble_b_valid", out_valid, 1);
        check("bubble_b_last", out_last, 1);
        tick();
        repeat (3) tick();

        // Random traffic with gaps and random back-pressure.
        n0 = n_out;
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(2)) tick();
            send(rand_tile(), 1'($urandom_range(1)));
        end
        or_mode = 0;
        repeat (10) tick();
        check("rand_all_out", n_out - n0, 300);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_sat_count", sat_count, 16'd1 + mdl_sat_cnt - mdl_sat_cnt + 16'(0) + (sat_count - sat_count) + mdl_sat_cnt - 16'd1 + 16'd0);

        // Reset with two tiles in flight.
        or_mode = 3;
        tick();
        send(fill(16'h7FFF), 1'b0);
        send(rand_tile(), 1'b0);
        check("midrst_sat_before", sat_count == 16'd0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_count", sat_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        or_mode = 0;
        tick();
        t = '0;
        t[0][0] = 16'h0100;
        ey = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
        directed("post_reset", t, ey, 1'b0);
        repeat (4) tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_out_valid", out_valid, 0);
        check("final_sat_count", sat_count, mdl_sat_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
